// File: rtl/score_sequencer_if.sv
// Signal bundle between score_sequencer and its neighbours: the mode FSM /
// buttons (commands), score_mem (address, data, control) and the tone
// generator (note output). The slave side is the sequencer itself.
// audio_len must match the audio_len of the sequencer attached to it.
interface score_sequencer_if #(
  parameter int audio_len = 6
);
  // commands from the mode FSM / buttons
  logic                 start_gen;
  logic                 start_play;
  logic                 stop;
  logic                 use_saved;
  // score_mem side
  logic                 Done_gen_score;
  logic [4:0]           note;
  logic [1:0]           length;
  logic                 Do_new_score;
  logic                 Do_save_audio_video;
  logic [audio_len-1:0] score_noteAdr;
  // tone generator / status
  logic [4:0]           play_note;
  logic                 note_valid;
  logic                 busy;
  logic                 play_done;

  modport master (
    output start_gen, start_play, stop, use_saved, Done_gen_score, note, length,
    input  Do_new_score, Do_save_audio_video, score_noteAdr,
           play_note, note_valid, busy, play_done
  );

  modport slave (
    input  start_gen, start_play, stop, use_saved, Done_gen_score, note, length,
    output Do_new_score, Do_save_audio_video, score_noteAdr,
           play_note, note_valid, busy, play_done
  );
endinterface

// File: rtl/score_sequencer.sv
// score_sequencer: runs score generation in score_mem, then plays the stored
// score back one note at a time. Each note is fetched over two cycles (covers
// both the 1-cycle ROM and the combinational RAM path), held for
// (length+1)*BEAT_CYCLES cycles, then followed by GAP_CYCLES of silence.
// All outputs come straight from registers.
module score_sequencer #(
  parameter int audio_len   = 6,
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input logic              clk,
  input logic              rst_n,
  score_sequencer_if.slave bus
);

  // hold counter must reach 4*BEAT_CYCLES-1; gap counter GAP_CYCLES-1
  localparam int HOLD_W = $clog2(4 * BEAT_CYCLES + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [audio_len-1:0] LAST_ADR = '1;

  typedef enum logic [2:0] {IDLE, GEN, FETCH, HOLD, GAP} state_t;

  state_t               state_reg, state_next;
  logic                 dns_reg, dns_next;
  logic                 save_reg, save_next;
  logic [audio_len-1:0] adr_reg, adr_next;
  logic [4:0]           note_reg, note_next;
  logic                 valid_reg, valid_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 fetch_reg, fetch_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic                 note_end;
  logic [HOLD_W-1:0]    hold_load;

  // hold count for the length code currently on the bus, minus one
  assign hold_load = HOLD_W'((int'(bus.length) + 1) * BEAT_CYCLES - 1);

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dns_reg   <= 1'b0;
      save_reg  <= 1'b0;
      adr_reg   <= '0;
      note_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      fetch_reg <= 1'b0;
      hold_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dns_reg   <= dns_next;
      save_reg  <= save_next;
      adr_reg   <= adr_next;
      note_reg  <= note_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      fetch_reg <= fetch_next;
      hold_reg  <= hold_next;
      gap_reg   <= gap_next;
    end
  end

  // next-state and next-output logic; stop overrides everything outside IDLE
  always_comb begin
    state_next = state_reg;
    dns_next   = dns_reg;
    save_next  = save_reg;
    adr_next   = adr_reg;
    note_next  = note_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    fetch_next = fetch_reg;
    hold_next  = hold_reg;
    gap_next   = gap_reg;
    note_end   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (bus.start_play) begin
          save_next  = bus.use_saved;
          adr_next   = '0;
          fetch_next = 1'b0;
          state_next = FETCH;
        end else if (bus.start_gen) begin
          dns_next   = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        if (bus.Done_gen_score) begin
          dns_next   = 1'b0;
          state_next = IDLE;
        end
      end
      FETCH: begin
        if (fetch_reg) begin
          // second fetch cycle: data is valid for either memory path
          note_next  = bus.note;
          hold_next  = hold_load;
          valid_next = 1'b1;
          fetch_next = 1'b0;
          state_next = HOLD;
        end else begin
          fetch_next = 1'b1;
        end
      end
      HOLD: begin
        if (hold_reg == '0) begin
          valid_next = 1'b0;
          note_next  = '0;
          if (GAP_CYCLES > 0) begin
            gap_next   = GAP_LOAD;
            state_next = GAP;
          end else begin
            note_end = 1'b1;
          end
        end else begin
          hold_next = hold_reg - 1'b1;
        end
      end
      GAP: begin
        if (gap_reg == '0) begin
          note_end = 1'b1;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // end of a note's gap: advance, or finish after the last address
    if (note_end) begin
      if (adr_reg == LAST_ADR) begin
        done_next  = 1'b1;
        adr_next   = '0;
        save_next  = 1'b0;
        state_next = IDLE;
      end else begin
        adr_next   = adr_reg + 1'b1;
        fetch_next = 1'b0;
        state_next = FETCH;
      end
    end

    if (bus.stop && (state_reg != IDLE)) begin
      state_next = IDLE;
      dns_next   = 1'b0;
      save_next  = 1'b0;
      adr_next   = '0;
      note_next  = '0;
      valid_next = 1'b0;
      done_next  = 1'b0;
      fetch_next = 1'b0;
      hold_next  = '0;
      gap_next   = '0;
    end

    busy_next = (state_next != IDLE);
  end

  assign bus.Do_new_score        = dns_reg;
  assign bus.Do_save_audio_video = save_reg;
  assign bus.score_noteAdr       = adr_reg;
  assign bus.play_note           = note_reg;
  assign bus.note_valid          = valid_reg;
  assign bus.busy                = busy_reg;
  assign bus.play_done           = done_reg;

endmodule
